uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Single-channel 8N1 UART receiver. It oversamples the serial input at TICKS_PER_BIT clocks per bit and assembles one byte, LSB first. The byte and a valid flag are held until the consumer acknowledges with a one-cycle strobe. The block sits between the external RX pin and the bus-side peripheral register logic.

Parameters:
TICKS_PER_BIT, 32, clk_i cycles per serial bit; legal range is 4 or more; elaboration error if smaller.

Ports:
clk_i  input  1  system clock; all logic is on the rising edge.
rst_ni  input  1  asynchronous active-low reset.
rx_i  input  1  serial line, asynchronous; idles high.
stb_i  input  1  consumer acknowledge; one-cycle pulse clears the valid flag.
valid_data_o  output  1  high while a received byte awaits acknowledge.
data_o  output  8  last correctly received byte.

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE, valid_data_o=0, data_o=8'h00, counters and shift register cleared, synchronizer flops set to 1.
- rx_i passes through a 2-flop synchronizer initialised high. All decisions use the synchronized value rx_s.
- Tick counter width is $clog2(TICKS_PER_BIT). The bit counter is 3 bits wide.
- State machine states: IDLE, START, DATA, STOP, DONE.
- IDLE
  - rx_s==0 → START, counter=0.
- START
  - Counts to TICKS_PER_BIT/2-1, which is mid start bit.
  - If rx_s is still 0 → DATA, counter=0, bit index=0.
  - Otherwise it is a glitch → IDLE.
- DATA
  - Counts to TICKS_PER_BIT-1, then samples rx_s into shift[bit index] (LSB first) and resets the counter.
  - After bit 7 → STOP.
- STOP
  - Counts to TICKS_PER_BIT-1, then samples rx_s.
  - If rx_s==1 → DONE: data_o<=shift, valid_data_o<=1 on that same edge.
  - If rx_s==0 (framing error) → IDLE: byte discarded, data_o and valid_data_o unchanged.
- DONE
  - Holds valid_data_o=1 and data_o.
  - Line activity is ignored; a frame arriving during DONE is lost.
  - stb_i==1 → IDLE with valid_data_o<=0 on that edge.
  - DONE is left only by stb_i or reset.
- stb_i is ignored in every state except DONE. It is not a reset: a partial frame is unaffected.
- data_o keeps its value after acknowledge. It changes only on the next successful frame.
- Latency: valid_data_o rises 2 + TICKS_PER_BIT/2 + 9*TICKS_PER_BIT clocks (±1) after the first low rx_i edge.
- Simultaneous events:
  - stb_i in the same cycle STOP completes is ignored, because the block is not yet in DONE.
- Mid-frame reset aborts the frame immediately.
- A line held low continuously produces a framing error, then IDLE, then a new START. There is no break detection.

Optional Feature:
UART_RX_FRAME_ERR_EN
- Defined: adds output frame_err_o (1 bit, reset 0).
  - Set on the STOP-sample edge when rx_s==0.
  - Sticky; cleared by stb_i in any state, or by reset.
  - A new successful frame does not clear it.
- Undefined: the port is absent and framing errors are discarded silently as above.

Decomposition:
- Package uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, DONE);
  - the constant DATA_BITS=8;
  - a helper for counter width.
- Natural sub-module: uart_rx_sync, the 2-flop synchronizer with parameterised reset value 1.

Test Plan:
- Reset, then idle-high line for 32 clocks → valid_data_o=0, data_o=8'h00.
- TICKS_PER_BIT=32, 10 ns clock. Send 8'hA5 (start, 1,0,1,0,0,1,0,1, stop), each bit 320 ns. Wait 640 ns → valid_data_o=1, data_o=8'hA5. Pulse stb_i for one cycle → valid_data_o=0 on the next edge, data_o stays 8'hA5.
- Low glitch on rx_i of 5 clocks → returns to IDLE, valid_data_o stays 0.
- Send 8'h3C with the stop bit driven low → valid_data_o=0, data_o unchanged. With UART_RX_FRAME_ERR_EN defined, frame_err_o=1 until stb_i.
- Send 8'h11 without acknowledging, then send 8'h22 → data_o stays 8'h11. After stb_i, send 8'h22 → data_o=8'h22.
- Assert rst_ni low mid-DATA of 8'hFF → outputs clear immediately, and the next full frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  localparam int DATA_BITS = 8;

  function automatic int cnt_w(input int ticks);
    return $clog2(ticks);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; reset value is configurable.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, byte held until acknowledged by stb_i.
// Define UART_RX_FRAME_ERR_EN to add the sticky frame_err_o output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int TICKS_PER_BIT = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic       stb_i,
  output logic       valid_data_o,
  output logic [7:0] data_o
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       frame_err_o
`endif
);

  localparam int CW = cnt_w(TICKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(TICKS_PER_BIT - 1);

  if (TICKS_PER_BIT < 4) begin : g_bad_ticks
    $error("uart_rx: TICKS_PER_BIT must be 4 or more");
  end

  uart_state_e          state, state_nxt;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [2:0]           bidx;
  logic [DATA_BITS-1:0] shift;
  logic                 half_hit, tick_hit, last_bit;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  assign half_hit = (cnt == HALF_LAST);
  assign tick_hit = (cnt == BIT_LAST);
  assign last_bit = (bidx == 3'(DATA_BITS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s)                state_nxt = START;
      START: if (half_hit)             state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (tick_hit && last_bit) state_nxt = STOP;
      STOP:  if (tick_hit)             state_nxt = rx_s ? DONE : IDLE;
      DONE:  if (stb_i)                state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_data_o = (state == DONE);
  end

  // Datapath: counters restart on every phase boundary; data_o only moves on a good stop bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      bidx   <= '0;
      shift  <= '0;
      data_o <= '0;
    end else begin
      case (state)
        START: begin
          cnt  <= half_hit ? '0 : cnt + CW'(1);
          bidx <= '0;
        end
        DATA: begin
          cnt <= tick_hit ? '0 : cnt + CW'(1);
          if (tick_hit) begin
            shift[bidx] <= rx_s;
            bidx        <= bidx + 3'd1;
          end
        end
        STOP: begin
          cnt <= tick_hit ? '0 : cnt + CW'(1);
          if (tick_hit && rx_s) data_o <= shift;
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  // A fresh framing error wins over a simultaneous acknowledge so it is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                 frame_err_o <= 1'b0;
    else if (state == STOP && tick_hit && !rx_s) frame_err_o <= 1'b1;
    else if (stb_i)                              frame_err_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx against a frame-level reference model.
module tb_uart_rx;

  localparam int TPB = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       stb = 1'b0;
  logic       valid;
  logic [7:0] data;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr;
`endif

  int passed = 0;
  int total  = 0;

  // Reference model: what the consumer should see, tracked per whole frame.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;

  always #5 clk = ~clk;

  uart_rx #(.TICKS_PER_BIT(TPB)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_i        (rx),
    .stb_i       (stb),
    .valid_data_o(valid),
    .data_o      (data)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .frame_err_o (ferr)
`endif
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, {7'd0, valid}, {7'd0, m_valid});
    check({tag, ".data"}, data, m_data);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Full frame; optional stb pulse in the middle of data bit stb_bit (-1 = none).
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stb_bit);
    rx = 1'b0;
    repeat (TPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (TPB/2) @(negedge clk);
      if (i == stb_bit) stb = 1'b1;
      @(negedge clk);
      stb = 1'b0;
      repeat (TPB/2 - 1) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (TPB) @(negedge clk);
    rx = 1'b1;
  endtask

  // Model update for a completed frame: lost while a byte is pending, dropped on bad stop.
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (good && !m_valid) begin
      m_valid = 1'b1;
      m_data  = b;
    end
  endtask

  task automatic ack();
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    m_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       good;
    int         sb;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(32);
    check_model("reset");

    send_frame(8'hA5, 1'b1, -1);
    model_frame(8'hA5, 1'b1);
    idle(64);
    check_model("rx_a5");
    ack();
    check_model("ack_a5");

    rx = 1'b0;
    repeat (5) @(negedge clk);
    idle(40);
    check_model("glitch");

    send_frame(8'h3C, 1'b0, -1);
    model_frame(8'h3C, 1'b0);
    idle(40);
    check_model("frame_err");
`ifdef UART_RX_FRAME_ERR_EN
    check("ferr_set", {7'd0, ferr}, 8'h01);
    ack();
    check("ferr_clr", {7'd0, ferr}, 8'h00);
`endif

    send_frame(8'h11, 1'b1, -1);
    model_frame(8'h11, 1'b1);
    idle(20);
    check_model("rx_11");
    send_frame(8'h22, 1'b1, -1);
    model_frame(8'h22, 1'b1);
    idle(20);
    check_model("lost_22");
    ack();
    check_model("ack_11");
    send_frame(8'h22, 1'b1, -1);
    model_frame(8'h22, 1'b1);
    idle(20);
    check_model("rx_22");
    ack();

    // Abort mid-DATA of 0xFF with reset; outputs must clear without a clock edge.
    rx = 1'b0;
    repeat (TPB) @(negedge clk);
    rx = 1'b1;
    repeat (4*TPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data  = 8'h00;
    check_model("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(TPB*6);
    check_model("post_reset_idle");
    send_frame(8'h5A, 1'b1, -1);
    model_frame(8'h5A, 1'b1);
    idle(20);
    check_model("rx_5a");

    for (int it = 0; it < 14; it++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      sb   = (!m_valid && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : -1;
      idle(int'($urandom_range(5, 30)));
      send_frame(b, good, sb);
      model_frame(b, good);
      idle(20);
      check_model($sformatf("rand%0d", it));
      if ($urandom_range(0, 1) == 1) begin
        ack();
        check_model($sformatf("rand%0d_ack", it));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
